// File: rtl/adsr_envelope.sv
// rtl/adsr_envelope.sv - ADSR envelope generator (optional macro ADSR_LEGATO_RETRIGGER_EN: rise keeps level)
module adsr_envelope (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        gate,
    input  logic [15:0] attack_rate,
    input  logic [15:0] decay_rate,
    input  logic [15:0] sustain_level,
    input  logic [15:0] release_rate,
    output logic [15:0] level,
    output logic [2:0]  stage,
    output logic        active
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ATTACK  = 3'd1;
    localparam logic [2:0] S_DECAY   = 3'd2;
    localparam logic [2:0] S_SUSTAIN = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]         state_q;
    logic [2:0]         state_n;
    logic [15:0]        level_n;
    logic               gate_d;
    logic               rise;
    logic               fall;
    logic               fall_exit;
    logic [16:0]        attack_sum;
    logic               attack_done;
    logic signed [16:0] decay_diff;
    logic               decay_done;
    logic               release_done;

    assign rise      = gate & ~gate_d;
    assign fall      = ~gate & gate_d;
    // A fall only matters while the note is still sounding its first three phases.
    assign fall_exit = fall && (state_q == S_ATTACK || state_q == S_DECAY || state_q == S_SUSTAIN);

    // A zero rate means "jump straight to the phase target on the next tick".
    assign attack_sum   = {1'b0, level} + {1'b0, attack_rate};
    assign attack_done  = (attack_rate == 16'd0) || attack_sum[16] || (attack_sum[15:0] == 16'hFFFF);
    assign decay_diff   = $signed({1'b0, level}) - $signed({1'b0, decay_rate});
    assign decay_done   = (decay_rate == 16'd0) || (decay_diff <= $signed({1'b0, sustain_level}));
    assign release_done = (release_rate == 16'd0) || (release_rate >= level);

    assign stage = state_q;

    // State, level, activity flag and gate history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            level   <= 16'd0;
            active  <= 1'b0;
            gate_d  <= 1'b0;
        end else begin
            state_q <= state_n;
            level   <= level_n;
            active  <= (state_n != S_IDLE);
            gate_d  <= gate;
        end
    end

    // Next-state: gate edges win over tick-driven phase progress.
    always_comb begin
        state_n = state_q;
        if (rise) begin
            state_n = S_ATTACK;
        end else if (fall_exit) begin
            state_n = S_RELEASE;
        end else if (tick) begin
            case (state_q)
                S_ATTACK:  if (attack_done)  state_n = S_DECAY;
                S_DECAY:   if (decay_done)   state_n = S_SUSTAIN;
                S_RELEASE: if (release_done) state_n = S_IDLE;
                default:   state_n = state_q;
            endcase
        end
    end

    // Next level: edge cycles never step the level; sustain tracks its input every clk.
    always_comb begin
        level_n = level;
        if (rise) begin
`ifdef ADSR_LEGATO_RETRIGGER_EN
            level_n = level;
`else
            level_n = 16'd0;
`endif
        end else if (fall_exit) begin
            level_n = level;
        end else begin
            case (state_q)
                S_IDLE:    level_n = 16'd0;
                S_ATTACK:  if (tick) level_n = attack_done ? 16'hFFFF : attack_sum[15:0];
                S_DECAY:   if (tick) level_n = decay_done ? sustain_level : decay_diff[15:0];
                S_SUSTAIN: level_n = sustain_level;
                S_RELEASE: if (tick) level_n = release_done ? 16'd0 : (level - release_rate);
                default:   level_n = 16'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_adsr_envelope.sv
// tb/tb_adsr_envelope.sv - scoreboard testbench for adsr_envelope
module tb_adsr_envelope;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        gate;
    logic [15:0] attack_rate;
    logic [15:0] decay_rate;
    logic [15:0] sustain_level;
    logic [15:0] release_rate;
    logic [15:0] level;
    logic [2:0]  stage;
    logic        active;

    typedef struct {
        string       tag;
        logic [2:0]  stage;
        logic [15:0] level;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef ADSR_LEGATO_RETRIGGER_EN
    localparam bit LEGATO = 1'b1;
`else
    localparam bit LEGATO = 1'b0;
`endif

    logic [15:0] retrig_lvl;

    adsr_envelope dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick          (tick),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .level         (level),
        .stage         (stage),
        .active        (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one clk cycle of inputs and queue the state expected after its rising edge.
    task automatic drive(input logic g, input logic t, input logic [2:0] es, input logic [15:0] el, input string tag);
        exp_t e;
        @(negedge clk);
        gate = g;
        tick = t;
        e.tag   = tag;
        e.stage = es;
        e.level = el;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Compare registered outputs just after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, "_stage"},  32'(stage),  32'(e.stage));
            check({e.tag, "_level"},  32'(level),  32'(e.level));
            check({e.tag, "_active"}, 32'(active), 32'(e.stage != 3'd0));
        end
    end

    initial begin
        rst_n         = 1'b0;
        gate          = 1'b0;
        tick          = 1'b0;
        attack_rate   = 16'h4000;
        decay_rate    = 16'h1000;
        sustain_level = 16'hC000;
        release_rate  = 16'h3000;
        #7;
        check("reset_stage",  32'(stage),  32'd0);
        check("reset_level",  32'(level),  32'd0);
        check("reset_active", 32'(active), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with ticks: nothing moves.
        for (int i = 0; i < 200; i++) drive(1'b0, (i % 4) == 0, 3'd0, 16'h0000, "idle");

        // Attack: rise cycle ignores tick, then saturating ramp.
        drive(1'b1, 1'b1, 3'd1, 16'h0000, "rise");
        drive(1'b1, 1'b1, 3'd1, 16'h4000, "atk1");
        drive(1'b1, 1'b0, 3'd1, 16'h4000, "atk_hold");
        drive(1'b1, 1'b1, 3'd1, 16'h8000, "atk2");
        drive(1'b1, 1'b1, 3'd1, 16'hC000, "atk3");
        drive(1'b1, 1'b1, 3'd2, 16'hFFFF, "atk_sat");

        // Decay to sustain, then sustain tracking without tick.
        drive(1'b1, 1'b1, 3'd2, 16'hEFFF, "dec1");
        drive(1'b1, 1'b1, 3'd2, 16'hDFFF, "dec2");
        drive(1'b1, 1'b1, 3'd2, 16'hCFFF, "dec3");
        drive(1'b1, 1'b1, 3'd3, 16'hC000, "dec_sus");
        sustain_level = 16'hA000;
        drive(1'b1, 1'b0, 3'd3, 16'hA000, "sus_track");

        // Release: fall cycle keeps level even with tick.
        drive(1'b0, 1'b1, 3'd4, 16'hA000, "fall");
        drive(1'b0, 1'b1, 3'd4, 16'h7000, "rel1");
        drive(1'b0, 1'b1, 3'd4, 16'h4000, "rel2");
        drive(1'b0, 1'b1, 3'd4, 16'h1000, "rel3");
        drive(1'b0, 1'b1, 3'd0, 16'h0000, "rel_end");
        drive(1'b0, 1'b1, 3'd0, 16'h0000, "idle_after");

        // Second note: zero decay rate is instant, retrigger during release.
        drive(1'b1, 1'b0, 3'd1, 16'h0000, "n2_rise");
        drive(1'b1, 1'b1, 3'd1, 16'h4000, "n2_atk1");
        drive(1'b1, 1'b1, 3'd1, 16'h8000, "n2_atk2");
        drive(1'b1, 1'b1, 3'd1, 16'hC000, "n2_atk3");
        drive(1'b1, 1'b1, 3'd2, 16'hFFFF, "n2_atk_sat");
        decay_rate = 16'h0000;
        drive(1'b1, 1'b1, 3'd3, 16'hA000, "dec_zero");
        drive(1'b0, 1'b0, 3'd4, 16'hA000, "n2_fall");
        drive(1'b0, 1'b1, 3'd4, 16'h7000, "n2_rel1");
        drive(1'b0, 1'b1, 3'd4, 16'h4000, "n2_rel2");
        retrig_lvl = LEGATO ? 16'h4000 : 16'h0000;
        drive(1'b1, 1'b1, 3'd1, retrig_lvl, "retrig");
        drive(1'b1, 1'b1, 3'd1, retrig_lvl + 16'h4000, "retrig_atk");

        // Zero release rate is instant.
        release_rate = 16'h0000;
        drive(1'b0, 1'b0, 3'd4, retrig_lvl + 16'h4000, "n3_fall");
        drive(1'b0, 1'b1, 3'd0, 16'h0000, "rel_zero");

        // Asynchronous reset mid-attack with gate held high.
        release_rate = 16'h3000;
        drive(1'b1, 1'b0, 3'd1, 16'h0000, "n4_rise");
        drive(1'b1, 1'b1, 3'd1, 16'h4000, "n4_atk1");
        drive(1'b1, 1'b1, 3'd1, 16'h8000, "n4_atk2");
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_stage",  32'(stage),  32'd0);
        check("async_rst_level",  32'(level),  32'd0);
        check("async_rst_active", 32'(active), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 3'd1, 16'h0000, "post_rst_rise");

        // Gate toggling every clk alternates attack/release with no level steps.
        drive(1'b0, 1'b1, 3'd4, 16'h0000, "tog_fall1");
        drive(1'b1, 1'b1, 3'd1, 16'h0000, "tog_rise1");
        drive(1'b0, 1'b0, 3'd4, 16'h0000, "tog_fall2");
        drive(1'b1, 1'b0, 3'd1, 16'h0000, "tog_rise2");

        // Zero attack rate, then sustain above peak collapses decay in one tick.
        attack_rate = 16'h0000;
        drive(1'b1, 1'b1, 3'd2, 16'hFFFF, "atk_zero");
        decay_rate    = 16'h1000;
        sustain_level = 16'hFFFF;
        drive(1'b1, 1'b1, 3'd3, 16'hFFFF, "sus_above");
        sustain_level = 16'h1234;
        drive(1'b1, 1'b0, 3'd3, 16'h1234, "sus_track2");
        drive(1'b0, 1'b0, 3'd4, 16'h1234, "n5_fall");
        drive(1'b0, 1'b1, 3'd0, 16'h0000, "rel_ge_level");

        @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adsr_envelope.md
ADSR_ENVELOPE -- requirements
Module: adsr_envelope

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have tick  in  1  envelope-rate enable, one clk cycle wide; level steps only when high.
REQ-004 SHALL have gate  in  1  one Trigger line from the step trigger stage; rising edge = note on, falling edge = note off.
REQ-005 SHALL have attack_rate  in  16  unsigned increment per tick in ATTACK.
REQ-006 SHALL have decay_rate  in  16  unsigned decrement per tick in DECAY.
REQ-007 SHALL have sustain_level  in  16  unsigned hold level.
REQ-008 SHALL have release_rate  in  16  unsigned decrement per tick in RELEASE.
REQ-009 SHALL have level  out  16  unsigned envelope value, registered.
REQ-010 SHALL have stage  out  3  current state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-011 SHALL have active  out  1  high whenever stage != IDLE, registered.

Function
REQ-012 SHALL register gate into gate_d every clk; rise = gate & ~gate_d, fall = ~gate & gate_d.
REQ-013 On rise, from any state, SHALL enter ATTACK on the same clk edge; level unchanged that cycle even if tick high.
REQ-014 On fall, from ATTACK, DECAY or SUSTAIN, SHALL enter RELEASE on the same edge; level unchanged that cycle; fall in IDLE or RELEASE ignored.
REQ-015 Edge handling SHALL occur every clk regardless of tick; edge-driven transitions take priority over tick-driven ones.
REQ-016 ATTACK, on tick: level = min(level + attack_rate, 0xFFFF) via 17-bit sum; when result is 0xFFFF, enter DECAY in the same edge.
REQ-017 DECAY, on tick: if level - decay_rate <= sustain_level (17-bit signed compare), level = sustain_level and enter SUSTAIN; else level -= decay_rate.
REQ-018 SUSTAIN: level SHALL track sustain_level every clk, tick-independent; exit only on fall.
REQ-019 RELEASE, on tick: if release_rate >= level, level = 0 and enter IDLE; else level -= release_rate.
REQ-020 IDLE: level SHALL hold 0.
REQ-021 Rate value 0 SHALL mean instant: stage target (0xFFFF, sustain_level, 0) reached on the next tick, same transition as REQ-016/017/019.
REQ-022 sustain_level >= level on entering DECAY SHALL yield SUSTAIN on the next tick with level = sustain_level.
REQ-023 rise and fall cannot coexist in one cycle; gate toggling every clk SHALL alternate ATTACK/RELEASE with no level steps except on ticks.
REQ-024 Outputs level, stage, active SHALL all be registers, one clk latency from the causing edge/tick.

Reset
REQ-025 rst_n low SHALL immediately force stage=IDLE, level=0, active=0, gate_d=0, independent of clk.
REQ-026 Reset mid-envelope SHALL discard all progress; after release, gate already high SHALL count as a rise on the first clk edge (gate_d=0).

Configuration
REQ-027 Macro ADSR_LEGATO_RETRIGGER_EN: defined -> rise per REQ-013 keeps current level and attack ramps from it.
REQ-028 Not defined -> rise forces level=0 on the same edge as entering ATTACK (hard restart); all other behaviour identical.

Verification
REQ-029 Reset, gate=0, tick every 4 clk, 200 clk -> stage=0, level=0, active=0 throughout.
REQ-030 attack_rate=0x4000, gate rise -> ticks give level 0x4000,0x8000,0xC000,0xFFFF, stage 1->2 on the saturating tick.
REQ-031 decay_rate=0x1000, sustain_level=0xC000 after REQ-030 -> level 0xEFFF,0xDFFF,0xCFFF, then 0xC000 and stage=3; change sustain_level to 0xA000 -> level=0xA000 next clk with no tick.
REQ-032 In SUSTAIN at 0xA000, release_rate=0x3000, gate fall -> stage=4, level 0x7000,0x4000,0x1000, then 0 and stage=0, active=0.
REQ-033 In RELEASE at level 0x4000, gate rise -> stage=1; with ADSR_LEGATO_RETRIGGER_EN level stays 0x4000, without it level=0 on that edge.
REQ-034 rst_n pulsed low mid-ATTACK at level 0x8000 while gate=1 -> level=0, stage=0 asynchronously; after rst_n high, stage=1 on first clk edge.
